// File: rtl/gsn_pkg.sv
// Types and helpers shared by the GarbageSortTop front-end blocks.
package gsn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

  localparam int PIX_W_DEF = 24;
  localparam int RES_W_DEF = 128;

  // Image dimension including the zero border on both sides.
  function automatic int padded_dim(input int dim, input int pad);
    return dim + 2 * pad;
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with a first-word-fall-through head; reads 0 when empty.
module result_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];
  assign count   = count_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; count_q gates every read so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one zero-padded frame into the convolution datapath and buffers
// the pooled results for a downstream consumer.
module conv_frame_sequencer
  import gsn_pkg::*;
#(
  parameter int IMG_W         = 32,
  parameter int IMG_H         = 32,
  parameter int PAD           = 1,
  parameter int PIX_W         = PIX_W_DEF,
  parameter int RES_W         = RES_W_DEF,
  parameter int N_RESULTS     = 256,
  parameter int RES_DEPTH     = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] s_pix,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] d_in,
  output logic             conv_start,
  input  logic [RES_W-1:0] pool_out,
  input  logic             pool_valid,
  output logic [RES_W-1:0] r_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow,
  output logic             timeout
);

  localparam int PW    = padded_dim(IMG_W, PAD);
  localparam int PH    = padded_dim(IMG_H, PAD);
  localparam int COL_W = cnt_width(PW);
  localparam int ROW_W = cnt_width(PH);
  localparam int RC_W  = $clog2(N_RESULTS + 1);
  localparam int DC_W  = cnt_width(DRAIN_TIMEOUT);
  localparam logic [RC_W-1:0] RES_TARGET = RC_W'(N_RESULTS);

  state_e                 state_q;
  logic [ROW_W-1:0]       row_q;
  logic [COL_W-1:0]       col_q;
  logic [PIX_W-1:0]       d_in_q;
  logic                   conv_start_q;
  logic                   frame_done_q;
  logic                   overflow_q;
  logic                   timeout_q;
  logic [RC_W-1:0]        res_cnt_q;
  logic [DC_W-1:0]        drain_cnt_q;

  logic                   is_pad;
  logic                   advance;
  logic                   last_col;
  logic                   last_row;
  logic                   pool_take;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accepted;
  logic                   dropped;
  logic [$clog2(RES_DEPTH):0] fifo_count;

  assign is_pad   = (int'(row_q) < PAD) || (int'(row_q) >= IMG_H + PAD) ||
                    (int'(col_q) < PAD) || (int'(col_q) >= IMG_W + PAD);
  assign last_col = (int'(col_q) == PW - 1);
  assign last_row = (int'(row_q) == PH - 1);
  assign advance  = (state_q == FEED) && (is_pad || s_valid);
  assign s_ready  = (state_q == FEED) && !is_pad && s_valid;

  assign pool_take = pool_valid && (state_q != IDLE);
  assign r_valid   = (fifo_count != '0);
  assign fifo_pop  = r_valid && r_ready;
  assign accepted  = pool_take && (!fifo_full || fifo_pop);
  assign dropped   = pool_take && fifo_full && !fifo_pop;

  result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pool_take),
    .pop   (fifo_pop),
    .din   (pool_out),
    .dout  (r_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      d_in_q       <= '0;
      conv_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      res_cnt_q    <= '0;
      drain_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      conv_start_q <= 1'b0;
      d_in_q       <= '0;
      if (accepted && res_cnt_q != RES_TARGET) res_cnt_q <= res_cnt_q + 1'b1;
      if (dropped) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q    <= FEED;
            row_q      <= '0;
            col_q      <= '0;
            res_cnt_q  <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        FEED: begin
          // Interior positions without a pixel hold the scan and emit a bubble.
          if (advance) begin
            conv_start_q <= 1'b1;
            d_in_q       <= is_pad ? '0 : s_pix;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                state_q     <= DRAIN;
                drain_cnt_q <= '0;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (res_cnt_q == RES_TARGET && fifo_empty) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end else if (int'(drain_cnt_q) == DRAIN_TIMEOUT - 1) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            timeout_q    <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_in       = d_in_q;
  assign conv_start = conv_start_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a 4x4 image with a 1-pixel border.
module tb_conv_frame_sequencer;

  localparam int PIX_W = 24;
  localparam int RES_W = 128;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic [PIX_W-1:0] s_pix;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] d_in;
  logic             conv_start;
  logic [RES_W-1:0] pool_out;
  logic             pool_valid;
  logic [RES_W-1:0] r_data;
  logic             r_valid;
  logic             r_ready;
  logic             busy;
  logic             frame_done;
  logic             overflow;
  logic             timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cs_cnt, rdy_cnt, done_cnt, busy_cnt, gaps;
  logic [PIX_W-1:0] dseq[$];
  logic [RES_W-1:0] popped[$];

  always #5 clk = ~clk;

  conv_frame_sequencer #(
    .IMG_W(4), .IMG_H(4), .PAD(1), .PIX_W(PIX_W), .RES_W(RES_W),
    .N_RESULTS(4), .RES_DEPTH(4), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .s_pix(s_pix), .s_valid(s_valid), .s_ready(s_ready),
    .d_in(d_in), .conv_start(conv_start),
    .pool_out(pool_out), .pool_valid(pool_valid),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix_val(input int i);
    return 24'hA50000 + 24'(i + 1);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_d_in"},       d_in,       0);
    check({tag, "_conv_start"}, conv_start, 0);
    check({tag, "_s_ready"},    s_ready,    0);
    check({tag, "_r_valid"},    r_valid,    0);
    check({tag, "_r_data"},     r_data,     0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_overflow"},   overflow,   0);
    check({tag, "_timeout"},    timeout,    0);
  endtask

  // Expected datapath stream: 6x6 raster, zeros on the border, pixels in arrival order.
  task automatic check_dseq(input string tag);
    int idx = 0;
    int mism = 0;
    int k = 0;
    logic [PIX_W-1:0] e;
    check({tag, "_len"}, dseq.size(), 36);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (r < 1 || r > 4 || c < 1 || c > 4) e = '0;
        else begin
          e = pix_val(idx);
          idx++;
        end
        if (k < dseq.size() && dseq[k] !== e) mism++;
        k++;
      end
    end
    check({tag, "_order"}, mism, 0);
  endtask

  task automatic check_popped(input string tag, input int n, input logic [RES_W-1:0] exp_vals [5]);
    int mism = 0;
    check({tag, "_cnt"}, popped.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i >= popped.size() || popped[i] !== exp_vals[i]) mism++;
    end
    check({tag, "_vals"}, mism, 0);
  endtask

  // vmode: 0 s_valid always 1, 1 toggling. pmode: 0 result every 9 cycles with r_ready=1,
  // 1 six back-to-back results with consumer stalled until the last, 2 like 0 but r_ready=0.
  task automatic run_frame(input int vmode, input int pmode, input int npool,
                           input int abort_at, input bit extra_start);
    int  idx = 0;
    int  pulses = 0;
    bit  seen_done = 1'b0;
    bit  finished = 1'b0;
    cs_cnt = 0; rdy_cnt = 0; done_cnt = 0; busy_cnt = 0; gaps = 0;
    dseq.delete();
    popped.delete();
    @(negedge clk);
    frame_start = 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      frame_start = extra_start && (cyc == 5);
      s_valid = (vmode == 0) ? 1'b1 : (cyc % 2 == 0);
      s_pix = pix_val(idx);
      pool_valid = 1'b0;
      if (pmode == 1) begin
        if (cyc >= 2 && cyc <= 7) begin
          pulses++;
          pool_valid = 1'b1;
          pool_out = RES_W'(pulses);
        end
        r_ready = (cyc >= 7);
      end else begin
        if (cyc % 9 == 8 && pulses < npool) begin
          pulses++;
          pool_valid = 1'b1;
          pool_out = RES_W'(pulses);
        end
        r_ready = (pmode == 0);
      end
      if (abort_at > 0 && rdy_cnt == abort_at) begin
        check("pre_rst_r_valid", r_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        s_valid = 1'b1;
        pool_valid = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        s_valid = 1'b0;
        return;
      end
      #1;
      if (s_ready) begin
        rdy_cnt++;
        idx++;
      end
      if (conv_start) begin
        cs_cnt++;
        dseq.push_back(d_in);
      end else if (cs_cnt > 0 && cs_cnt < 36) begin
        gaps++;
      end
      if (r_valid && r_ready) popped.push_back(r_data);
      busy_cnt += int'(busy);
      if (frame_done) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      if (seen_done && !busy) finished = 1'b1;
    end
    s_valid = 1'b0;
    pool_valid = 1'b0;
    frame_start = 1'b0;
    check("frame_end_in_budget", finished, 1);
  endtask

  logic [RES_W-1:0] exp_pop [5];

  initial begin
    rst = 1'b1; frame_start = 1'b0; s_valid = 1'b0; s_pix = '0;
    pool_valid = 1'b0; pool_out = '0; r_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Steady source: full padded stream, four results consumed immediately.
    run_frame(0, 0, 4, 0, 1'b0);
    check("t1_conv_cycles", cs_cnt, 36);
    check("t1_handshakes", rdy_cnt, 16);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_bubbles", gaps, 0);
    check_dseq("t1_dseq");
    check("t1_first_pad", dseq[0], 0);
    check("t1_first_pix", dseq[7], pix_val(0));
    check("t1_last_pad", dseq[35], 0);
    exp_pop = '{RES_W'(1), RES_W'(2), RES_W'(3), RES_W'(4), '0};
    check_popped("t1_pop", 4, exp_pop);
    check("t1_overflow", overflow, 0);
    check("t1_timeout", timeout, 0);

    // Toggling source: one bubble before every interior pixel.
    run_frame(1, 0, 4, 0, 1'b0);
    check("t2_conv_cycles", cs_cnt, 36);
    check("t2_handshakes", rdy_cnt, 16);
    check("t2_bubbles", gaps, 16);
    check_dseq("t2_dseq");
    check("t2_done_pulses", done_cnt, 1);

    // Stalled consumer: fifth result dropped, push-with-pop at full keeps the sixth.
    run_frame(0, 1, 0, 0, 1'b0);
    check("t3_overflow", overflow, 1);
    check("t3_timeout", timeout, 0);
    exp_pop = '{RES_W'(1), RES_W'(2), RES_W'(3), RES_W'(4), RES_W'(6)};
    check_popped("t3_pop", 5, exp_pop);
    check("t3_done_pulses", done_cnt, 1);

    // Only three results: 36 FEED + 16 DRAIN + 1 DONE busy cycles.
    run_frame(0, 0, 3, 0, 1'b0);
    check("t4_timeout", timeout, 1);
    check("t4_overflow_cleared", overflow, 0);
    check("t4_done_pulses", done_cnt, 1);
    check("t4_busy_cycles", busy_cnt, 53);
    check("t4_busy_fell", busy, 0);

    // frame_start during FEED is ignored; sticky timeout clears on the new frame.
    run_frame(0, 0, 4, 0, 1'b1);
    check("t6_conv_cycles", cs_cnt, 36);
    check_dseq("t6_dseq");
    check("t6_done_pulses", done_cnt, 1);
    check("t6_timeout_cleared", timeout, 0);

    // pool_valid while idle is neither buffered nor flagged.
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pool_valid = 1'b1;
      pool_out = RES_W'(32'hDEAD0000 + i);
    end
    @(negedge clk);
    pool_valid = 1'b0;
    #1;
    check("idle_pool_r_valid", r_valid, 0);
    check("idle_pool_overflow", overflow, 0);
    check("idle_pool_busy", busy, 0);

    // Reset after the tenth pixel handshake aborts without frame_done.
    run_frame(0, 2, 4, 10, 1'b0);
    check("t5_no_done", done_cnt, 0);
    run_frame(0, 0, 4, 0, 1'b0);
    check("t5_replay_conv_cycles", cs_cnt, 36);
    check("t5_replay_handshakes", rdy_cnt, 16);
    check_dseq("t5_replay_dseq");
    check("t5_replay_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
Sequences one image frame into the GarbageSortTop convolution datapath. It pulls RGB pixels from an upstream valid/ready source and inserts zero padding at the frame borders. It drives the datapath pixel bus (d_in) and its enable (conv_start), then collects pool_out results into a small result FIFO for a downstream consumer. It sits between the frame buffer/DMA and GarbageSortTop and reports frame completion, overflow and timeout status.

Parameters:
IMG_W, 32, interior image width in pixels (>=1)
IMG_H, 32, interior image height in pixels (>=1)
PAD, 1, zero-pad border width on every side (0..3)
PIX_W, 24, pixel width (8-bit R,G,B)
RES_W, 128, pool_out result width
N_RESULTS, 256, pool_out words expected per frame
RES_DEPTH, 4, result FIFO depth (power of two, >=2)
DRAIN_TIMEOUT, 1024, maximum drain cycles before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse; accepted only in IDLE
s_pix  in  PIX_W  upstream pixel
s_valid  in  1  upstream pixel valid
s_ready  out  1  pixel consumed this cycle
d_in  out  PIX_W  pixel to datapath (0 when padding)
conv_start  out  1  datapath enable; high when d_in carries a padded-frame pixel
pool_out  in  RES_W  datapath result
pool_valid  in  1  pool_out valid
r_data  out  RES_W  FIFO head
r_valid  out  1  FIFO not empty
r_ready  in  1  consumer pop
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse on DONE
overflow  out  1  sticky; set when pool_valid arrives while FIFO full
timeout  out  1  sticky; set on drain timeout

Behaviour:
- Reset: state IDLE; every output 0 (d_in=0, r_data=0); counters and FIFO cleared; sticky flags cleared. Reset mid-frame aborts immediately with no frame_done.
- States: IDLE -> FEED on frame_start. FEED -> DRAIN after the last padded pixel issues. DRAIN -> DONE when res_cnt==N_RESULTS and FIFO empty, or when drain_cnt reaches DRAIN_TIMEOUT (set timeout). DONE -> IDLE after one cycle.
- Sticky flags clear only on the frame_start that leaves IDLE, and on reset.
- FEED scans row 0..IMG_H+2*PAD-1 and, within each row, col 0..IMG_W+2*PAD-1, raster order.
- A position is pad if row<PAD, row>=IMG_H+PAD, col<PAD or col>=IMG_W+PAD.
- Pad position: registered d_in=0, conv_start=1, s_ready=0; advance every cycle.
- Interior position: s_ready=s_valid (combinational). On s_valid, d_in<=s_pix, conv_start<=1 and advance. Otherwise conv_start<=0 (bubble) and hold.
- d_in/conv_start are registered: a pixel is presented 1 cycle after its counter position is processed. Exactly (IMG_W+2P)*(IMG_H+2P) conv_start-high cycles and IMG_W*IMG_H s_ready handshakes occur per frame.
- conv_start is 0 outside FEED (plus the one trailing register cycle).
- Result FIFO: push on pool_valid in any non-IDLE state. Pop on r_valid&r_ready. Simultaneous push and pop when full is legal (no overflow). Push while full without pop drops the word and sets overflow. r_data is registered/first-word-fall-through from the FIFO head.
- res_cnt counts accepted pushes and saturates at N_RESULTS. Extra results after N_RESULTS are still buffered.
- drain_cnt counts from 0 on DRAIN entry. Timeout fires when drain_cnt==DRAIN_TIMEOUT-1.
- pool_valid in IDLE is ignored (not pushed, not counted).
- frame_start while busy is ignored.
- Counter widths are $clog2 of the padded dimension, minimum 1.

Decomposition:
- Shared package gsn_pkg: state enum (IDLE, FEED, DRAIN, DONE), PIX_W/RES_W defaults, and a padded-dimension function.
- One sub-module, result_fifo: parameterised sync FIFO (width, depth) with push/pop/full/empty/count. It is reused elsewhere in the network.

Test Plan:
- IMG_W=IMG_H=4, PAD=1, s_valid always 1, N_RESULTS=4, one result per 9 pixels, r_ready=1 -> 36 conv_start cycles, 16 s_ready pulses, rows 0/5 and cols 0/5 give d_in=0, frame_done once, no flags.
- Same config, s_valid toggling 1010 -> conv_start drops only at interior bubbles, d_in sequence equals s_pix order, still 36 high cycles total.
- r_ready=0, RES_DEPTH=4, 5 pool_valid pulses -> FIFO holds 4, overflow=1. Then r_ready=1 with a simultaneous push at full -> no further drops.
- Only 3 of 4 results returned, DRAIN_TIMEOUT=16 -> timeout=1 after 16 DRAIN cycles, frame_done pulses, busy falls.
- rst=1 asserted mid-FEED at pixel 10 -> next cycle all outputs 0, IDLE. A new frame_start then replays from row 0, col 0.
- frame_start pulsed during FEED and pool_valid in IDLE -> both ignored; the counter sequence and res_cnt are unchanged.
